// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller and the renderers it arbitrates.
package game_pkg;

  localparam int unsigned SECS_W = 3;
  localparam int unsigned RGB_W  = 8;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RESPAWN = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  localparam logic [RGB_W-1:0] BG_RGB          = 8'h00;
  // Key colour renderers treat as "no pixel" when generating their *_on flags.
  localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 8'b01011101;

endpackage

// File: rtl/sec_timer.sv
// Per-state seconds timer: cycle counter, one-cycle tick on wrap, saturating seconds count.
module sec_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              sec_tick,
  output logic [SECS_W-1:0] secs,
  output logic              wrap_c
);

  localparam int unsigned      CYC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(CLK_HZ - 1);

  logic [CYC_W-1:0]  r_cyc;
  logic [SECS_W-1:0] r_secs;
  logic              r_tick;

  assign wrap_c   = (r_cyc == CYC_MAX);
  assign sec_tick = r_tick;
  assign secs     = r_secs;

  // Clear wins over a coincident wrap so the new state starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc  <= '0;
      r_secs <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cyc  <= '0;
      r_secs <= '0;
      r_tick <= 1'b0;
    end else if (wrap_c) begin
      r_cyc  <= '0;
      r_tick <= 1'b1;
      if (r_secs != '1) begin
        r_secs <= r_secs + SECS_W'(1);
      end
    end else begin
      r_cyc  <= r_cyc + CYC_W'(1);
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game screen sequencer: START/PLAY/RESPAWN/OVER flow, lives count and
// per-pixel arbitration of the renderer overlays into one VGA colour.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned START_SECS   = 5,
  parameter int unsigned RESPAWN_SECS = 1,
  parameter int unsigned OVER_SECS    = 3,
  parameter int unsigned LIVES        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             player_hit,
  input  logic             start_on,
  input  logic [RGB_W-1:0] start_rgb,
  input  logic             over_on,
  input  logic [RGB_W-1:0] over_rgb,
  input  logic             play_on,
  input  logic [RGB_W-1:0] play_rgb,
  output logic [1:0]       state,
  output logic             play_enable,
  output logic [1:0]       lives,
  output logic             sec_tick,
  output logic [RGB_W-1:0] pixel_rgb
);

  localparam int unsigned       CNT_W       = SECS_W + 1;
  localparam logic [CNT_W-1:0]  START_LIM   = CNT_W'(START_SECS);
  localparam logic [CNT_W-1:0]  RESPAWN_LIM = CNT_W'(RESPAWN_SECS);
  localparam logic [SECS_W-1:0] OVER_LIM    = SECS_W'(OVER_SECS);
  localparam logic [1:0]        LIVES_INIT  = 2'(LIVES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_lives;
  logic [1:0]        w_lives_nxt;
  logic              r_play_enable;
  logic              r_btn_d;
  logic              r_btn_armed;
  logic              w_btn_rise;
  logic              w_clr;
  logic              w_wrap;
  logic              w_sec_tick;
  logic [SECS_W-1:0] w_secs;
  logic [CNT_W-1:0]  w_secs_inc;

  sec_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .sec_tick(w_sec_tick),
    .secs    (w_secs),
    .wrap_c  (w_wrap)
  );

  // Not armed in the first cycle after reset, so a button held through reset gives no rise.
  assign w_btn_rise = btn_start & ~r_btn_d & r_btn_armed;
  assign w_secs_inc = {1'b0, w_secs} + CNT_W'(1);
  assign w_clr      = (w_state_nxt != r_state);

  // Next-state and lives; timed exits fire on the wrap that completes the last second.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    case (r_state)
      ST_START: begin
        if (w_btn_rise || (w_wrap && (w_secs_inc == START_LIM))) begin
          w_state_nxt = ST_PLAY;
          w_lives_nxt = LIVES_INIT;
        end
      end
      ST_PLAY: begin
        if (player_hit) begin
          if (r_lives == 2'd1) begin
            w_state_nxt = ST_OVER;
            w_lives_nxt = 2'd0;
          end else begin
            w_state_nxt = ST_RESPAWN;
            w_lives_nxt = r_lives - 2'd1;
          end
        end
      end
      ST_RESPAWN: begin
        if (w_wrap && (w_secs_inc == RESPAWN_LIM)) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_OVER: begin
        w_lives_nxt = 2'd0;
        if (w_btn_rise && (w_secs >= OVER_LIM)) begin
          w_state_nxt = ST_START;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_START;
      r_lives       <= LIVES_INIT;
      r_play_enable <= 1'b0;
      r_btn_d       <= 1'b0;
      r_btn_armed   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_play_enable <= (r_state == ST_PLAY);
      r_btn_d       <= btn_start;
      r_btn_armed   <= 1'b1;
    end
  end

  // Zero-latency overlay priority: start screen, game-over screen, playfield, background.
  always_comb begin
    pixel_rgb = BG_RGB;
    if ((r_state == ST_START) && start_on) begin
      pixel_rgb = start_rgb;
    end else if ((r_state == ST_OVER) && over_on) begin
      pixel_rgb = over_rgb;
    end else if ((r_state != ST_START) && play_on) begin
      pixel_rgb = play_rgb;
    end
  end

  assign state       = r_state;
  assign play_enable = r_play_enable;
  assign lives       = r_lives;
  assign sec_tick    = w_sec_tick;

endmodule
